// File: rtl/crack_scheduler_if.sv
// Handshake bundle between crack_scheduler and its control port and crack cores.
// master is the scheduler side, slave is the top-level/worker side.
interface crack_scheduler_if #(
    parameter int NWORKERS = 2,
    parameter int KEY_W    = 24
);
    logic                      en;
    logic                      rdy;
    logic                      key_valid;
    logic [KEY_W-1:0]          key;
    logic [NWORKERS-1:0]       w_start;
    logic [NWORKERS*KEY_W-1:0] w_base;
    logic                      w_abort;
    logic [NWORKERS-1:0]       w_rdy;
    logic [NWORKERS-1:0]       w_done;
    logic [NWORKERS-1:0]       w_found;
    logic [NWORKERS*KEY_W-1:0] w_key;

    modport master (
        input  en, w_rdy, w_done, w_found, w_key,
        output rdy, key_valid, key, w_start, w_base, w_abort
    );

    modport slave (
        output en, w_rdy, w_done, w_found, w_key,
        input  rdy, key_valid, key, w_start, w_base, w_abort
    );
endinterface

// File: rtl/crack_scheduler.sv
// Splits the key space into blocks, dispatches them to crack cores, and stops
// all cores on the first reported hit.
module crack_scheduler #(
    parameter int NWORKERS  = 2,
    parameter int KEY_W     = 24,
    parameter int BLOCK_LOG = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    crack_scheduler_if.master   bus
);
    localparam logic [KEY_W:0] BLOCK_STEP = {{KEY_W{1'b0}}, 1'b1} << BLOCK_LOG;

    typedef enum logic [1:0] {IDLE, RUN, ABORT, DONE} state_t;

    state_t                    state, state_nxt;
    logic [KEY_W:0]            next_base, next_base_nxt;
    logic [NWORKERS-1:0]       busy, busy_nxt;
    logic                      hit, hit_nxt;
    logic                      key_valid_nxt, rdy_nxt, w_abort_nxt;
    logic [KEY_W-1:0]          key_nxt;
    logic [NWORKERS-1:0]       w_start_nxt;
    logic [NWORKERS*KEY_W-1:0] w_base_nxt;

    logic [NWORKERS-1:0]       found_vec;
    logic                      found_any;
    logic [KEY_W-1:0]          found_key;
    logic                      found_pick;
    logic [NWORKERS-1:0]       cand;
    logic [KEY_W:0]            base_src;
    logic                      do_disp;
    logic                      disp_pick;

    assign found_vec = bus.w_done & bus.w_found;
    assign found_any = |found_vec;

    // Lowest-index hit wins when several cores report in the same cycle.
    always_comb begin
        found_key  = '0;
        found_pick = 1'b0;
        for (int unsigned i = 0; i < NWORKERS; i++) begin
            if (found_vec[i] && !found_pick) begin
                found_pick = 1'b1;
                found_key  = bus.w_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.en) state_nxt = RUN;
            RUN: begin
                if (found_any)
                    state_nxt = ABORT;
                else if (next_base[KEY_W] && ((busy & ~bus.w_done) == '0))
                    state_nxt = DONE;
            end
            ABORT: if (&bus.w_rdy) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Computes the next value of every registered output and datapath register.
    always_comb begin
        next_base_nxt = next_base;
        busy_nxt      = busy;
        hit_nxt       = hit;
        key_nxt       = bus.key;
        key_valid_nxt = bus.key_valid;
        w_start_nxt   = '0;
        w_base_nxt    = bus.w_base;
        cand          = '0;
        base_src      = next_base;
        do_disp       = 1'b0;
        disp_pick     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.en) begin
                    key_valid_nxt = 1'b0;
                    key_nxt       = '0;
                    hit_nxt       = 1'b0;
                    busy_nxt      = '0;
                    next_base_nxt = '0;
                    base_src      = '0;
                    cand          = bus.w_rdy;
                    do_disp       = 1'b1;
                end
            end
            RUN: begin
                busy_nxt = busy & ~bus.w_done;
                if (found_any) begin
                    key_nxt = found_key;
                    hit_nxt = 1'b1;
                end else begin
                    cand    = bus.w_rdy & ~busy & ~bus.w_done;
                    do_disp = !next_base[KEY_W];
                end
            end
            ABORT: begin
                if (&bus.w_rdy) begin
                    busy_nxt      = '0;
                    key_valid_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        if (do_disp) begin
            for (int unsigned i = 0; i < NWORKERS; i++) begin
                if (cand[i] && !disp_pick) begin
                    disp_pick                       = 1'b1;
                    w_start_nxt[i]                  = 1'b1;
                    w_base_nxt[i*KEY_W +: KEY_W]    = base_src[KEY_W-1:0];
                    busy_nxt[i]                     = 1'b1;
                    next_base_nxt                   = base_src + BLOCK_STEP;
                end
            end
        end
        rdy_nxt     = (state_nxt == IDLE) || (state_nxt == DONE);
        w_abort_nxt = (state_nxt == ABORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_base     <= '0;
            busy          <= '0;
            hit           <= 1'b0;
            bus.rdy       <= 1'b1;
            bus.key_valid <= 1'b0;
            bus.key       <= '0;
            bus.w_start   <= '0;
            bus.w_base    <= '0;
            bus.w_abort   <= 1'b0;
        end else begin
            next_base     <= next_base_nxt;
            busy          <= busy_nxt;
            hit           <= hit_nxt;
            bus.rdy       <= rdy_nxt;
            bus.key_valid <= key_valid_nxt;
            bus.key       <= key_nxt;
            bus.w_start   <= w_start_nxt;
            bus.w_base    <= w_base_nxt;
            bus.w_abort   <= w_abort_nxt;
        end
    end
endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler with two behavioural crack cores of
// configurable latency and a configurable pair of target keys.
module tb_crack_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crack_scheduler_if #(.NWORKERS(2), .KEY_W(24)) bus ();

    crack_scheduler #(.NWORKERS(2), .KEY_W(24), .BLOCK_LOG(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Worker model controls
    int          lat [2];
    logic [1:0]  stall;
    logic [23:0] hk [2];
    logic [1:0]  hk_on;
    logic [1:0]  inj_done;
    logic [23:0] inj_key;

    logic [1:0]  active, m_done, m_found;
    logic [23:0] m_key [2];
    logic [23:0] job_base [2];
    int          cnt [2];

    assign bus.w_rdy   = ~active & ~stall;
    assign bus.w_done  = m_done | inj_done;
    assign bus.w_found = m_found | inj_done;
    assign bus.w_key   = {(inj_done[1] ? inj_key : m_key[1]), m_key[0]};

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= '0;
            m_done  <= '0;
            m_found <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i]      <= 0;
                m_key[i]    <= '0;
                job_base[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i]  <= 1'b0;
                m_found[i] <= 1'b0;
                if (bus.w_abort) begin
                    active[i] <= 1'b0;
                end else if (bus.w_start[i]) begin
                    active[i]   <= 1'b1;
                    cnt[i]      <= lat[i];
                    job_base[i] <= bus.w_base[i*24 +: 24];
                end else if (active[i]) begin
                    cnt[i] <= cnt[i] - 1;
                    if (cnt[i] == 1) begin
                        active[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                        if (hk_on[0] && hk[0][23:20] == job_base[i][23:20]) begin
                            m_found[i] <= 1'b1;
                            m_key[i]   <= hk[0];
                        end else if (hk_on[1] && hk[1][23:20] == job_base[i][23:20]) begin
                            m_found[i] <= 1'b1;
                            m_key[i]   <= hk[1];
                        end
                    end
                end
            end
        end
    end

    // Start/done monitor
    logic [23:0] sb [$];
    int          sw [$];
    int          sc [$];
    int          found_cyc;
    int          last_done_cyc;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (bus.w_start[i]) begin
                    sb.push_back(bus.w_base[i*24 +: 24]);
                    sw.push_back(i);
                    sc.push_back(cyc);
                end
            end
            if (found_cyc < 0 && (|(bus.w_done & bus.w_found))) found_cyc = cyc;
            if (|bus.w_done) last_done_cyc = cyc;
        end
    end

    task automatic clear_log();
        sb.delete();
        sw.delete();
        sc.delete();
        found_cyc = -1;
        last_done_cyc = -1;
    endtask

    task automatic start_run();
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int at_cyc);
        int n;
        n = 0;
        at_cyc = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rdy && n < budget);
        checks++;
        if (bus.rdy !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: rdy=%b required 1 within %0d cycles", bus.rdy, budget);
        end else begin
            at_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rdy !== 1'b1 || bus.key_valid !== 1'b0 || bus.key !== 24'h0 ||
            bus.w_start !== 2'b00 || bus.w_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: rdy=%b kv=%b key=%h start=%b abort=%b required 1 0 000000 00 0",
                     bus.rdy, bus.key_valid, bus.key, bus.w_start, bus.w_abort);
        end
        clear_log();
        start_run();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rdy !== 1'b1 || bus.key_valid !== 1'b0 || bus.key !== 24'h0 ||
            bus.w_start !== 2'b00 || bus.w_abort !== 1'b0 || bus.w_base !== 48'h0) begin
            errors++;
            $display("FAIL reset_midrun: rdy=%b kv=%b key=%h start=%b abort=%b base=%h required 1 0 000000 00 0 0",
                     bus.rdy, bus.key_valid, bus.key, bus.w_start, bus.w_abort, bus.w_base);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        start_run();
        checks++;
        if (bus.w_start !== 2'b01 || bus.w_base[23:0] !== 24'h000000 || bus.rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_start: start=%b base0=%h rdy=%b required 01 000000 0",
                     bus.w_start, bus.w_base[23:0], bus.rdy);
        end
        wait_idle(1000, t);
    endtask

    task automatic test_no_hit();
        int t;
        logic [23:0] exp_b;
        clear_log();
        start_run();
        wait_idle(1000, t);
        checks++;
        if (sb.size() != 16) begin
            errors++;
            $display("FAIL no_hit_count: starts=%0d required 16", sb.size());
        end
        for (int k = 0; k < sb.size() && k < 16; k++) begin
            exp_b = 24'(k) << 20;
            checks++;
            if (sb[k] !== exp_b || sw[k] != (k % 2)) begin
                errors++;
                $display("FAIL no_hit_seq[%0d]: base=%h worker=%0d required %h %0d",
                         k, sb[k], sw[k], exp_b, k % 2);
            end
        end
        checks++;
        if (t != last_done_cyc + 1) begin
            errors++;
            $display("FAIL no_hit_rdy_latency: rdy_cycle=%0d required %0d", t, last_done_cyc + 1);
        end
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_hit_kv: key_valid=%b required 0", bus.key_valid);
        end
    endtask

    task automatic wait_abort(output int at_cyc);
        int n;
        n = 0;
        at_cyc = -1;
        while (bus.w_abort !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.w_abort !== 1'b1) begin
            errors++;
            $display("FAIL wait_abort: w_abort=%b required 1 within 300 cycles", bus.w_abort);
        end else begin
            at_cyc = cyc;
        end
    endtask

    task automatic test_hit();
        int a, t, late;
        hk[0] = 24'h3ABCDE;
        hk_on = 2'b01;
        clear_log();
        start_run();
        wait_abort(a);
        checks++;
        if (a != found_cyc + 1) begin
            errors++;
            $display("FAIL hit_abort_latency: abort_cycle=%0d required %0d", a, found_cyc + 1);
        end
        late = 0;
        for (int k = 0; k < sc.size(); k++) if (sc[k] > found_cyc) late++;
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL hit_no_start_after: late_starts=%0d required 0", late);
        end
        for (int k = 0; k < sb.size(); k++) begin
            checks++;
            if (sb[k] !== (24'(k) << 20)) begin
                errors++;
                $display("FAIL hit_seq[%0d]: base=%h required %h", k, sb[k], 24'(k) << 20);
            end
        end
        wait_idle(100, t);
        checks++;
        if (bus.key !== 24'h3ABCDE || bus.key_valid !== 1'b1 || bus.w_rdy !== 2'b11 || bus.w_abort !== 1'b0) begin
            errors++;
            $display("FAIL hit_result: key=%h kv=%b w_rdy=%b abort=%b required 3abcde 1 11 0",
                     bus.key, bus.key_valid, bus.w_rdy, bus.w_abort);
        end
        hk_on = 2'b00;
    endtask

    task automatic test_simultaneous();
        int a, t;
        lat[0] = 6;
        lat[1] = 5;
        hk[0] = 24'h000007;
        hk[1] = 24'h100005;
        hk_on = 2'b11;
        clear_log();
        start_run();
        wait_abort(a);
        inj_key  = 24'hABCDEF;
        inj_done = 2'b10;
        @(negedge clk);
        inj_done = 2'b00;
        wait_idle(100, t);
        checks++;
        if (bus.key !== 24'h000007 || bus.key_valid !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous_key: key=%h kv=%b required 000007 1", bus.key, bus.key_valid);
        end
        hk_on = 2'b00;
        lat[0] = 5;
        lat[1] = 5;
    endtask

    task automatic test_protocol();
        int t;
        hk[0] = 24'h3ABCDE;
        hk_on = 2'b01;
        clear_log();
        start_run();
        wait_idle(1000, t);
        hk_on = 2'b00;
        clear_log();
        start_run();
        checks++;
        if (bus.key_valid !== 1'b0 || bus.key !== 24'h0 || bus.rdy !== 1'b0 ||
            bus.w_start !== 2'b01 || bus.w_base[23:0] !== 24'h0) begin
            errors++;
            $display("FAIL restart_from_done: kv=%b key=%h rdy=%b start=%b base0=%h required 0 000000 0 01 000000",
                     bus.key_valid, bus.key, bus.rdy, bus.w_start, bus.w_base[23:0]);
        end
        repeat (8) @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_idle(1000, t);
        checks++;
        if (sb.size() != 16) begin
            errors++;
            $display("FAIL en_in_run_count: starts=%0d required 16", sb.size());
        end
        for (int k = 0; k < sb.size() && k < 16; k++) begin
            checks++;
            if (sb[k] !== (24'(k) << 20)) begin
                errors++;
                $display("FAIL en_in_run_seq[%0d]: base=%h required %h", k, sb[k], 24'(k) << 20);
            end
        end
    endtask

    task automatic test_stall();
        int t, other;
        stall = 2'b10;
        clear_log();
        start_run();
        wait_idle(2000, t);
        checks++;
        if (sb.size() != 16) begin
            errors++;
            $display("FAIL stall_count: starts=%0d required 16", sb.size());
        end
        other = 0;
        for (int k = 0; k < sb.size() && k < 16; k++) begin
            if (sw[k] != 0) other++;
            checks++;
            if (sb[k] !== (24'(k) << 20)) begin
                errors++;
                $display("FAIL stall_seq[%0d]: base=%h required %h", k, sb[k], 24'(k) << 20);
            end
        end
        checks++;
        if (other != 0 || bus.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_worker: w1_starts=%0d kv=%b required 0 0", other, bus.key_valid);
        end
        stall = 2'b00;
    endtask

    initial begin
        bus.en   = 1'b0;
        lat[0]   = 5;
        lat[1]   = 5;
        stall    = 2'b00;
        hk[0]    = '0;
        hk[1]    = '0;
        hk_on    = 2'b00;
        inj_done = 2'b00;
        inj_key  = '0;
        found_cyc = -1;
        last_done_cyc = -1;
        test_reset();
        test_no_hit();
        test_hit();
        test_simultaneous();
        test_protocol();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/crack_scheduler.md
# crack_scheduler

Sequences the parallel ARC4 key-search datapath. It splits the 24-bit key space into fixed-size blocks and hands them to NWORKERS crack cores over a start/done handshake. On the first reported hit it latches the key, aborts all cores, and reports completion through the standard `rdy`/`en` protocol. It sits between the top level (`CLOCK_50` → `clk`, `KEY[3]` → `rst_n`) and the crack core instances that share the ciphertext memory.

## Interface
- NWORKERS, 2: number of crack cores scheduled.
- KEY_W, 24: key width in bits.
- BLOCK_LOG, 20: log2 of keys per block; blocks = 2^(KEY_W−BLOCK_LOG).
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- en  in  1  start pulse; honoured only while rdy=1.
- rdy  out  1  high when idle (IDLE or DONE).
- key_valid  out  1  high in DONE if a key was found.
- key  out  KEY_W  found key; held until next accepted en.
- w_start  out  NWORKERS  one-cycle start pulse per worker.
- w_base  out  NWORKERS*KEY_W  block base key per worker; stable while that worker is busy.
- w_abort  out  1  level; forces all workers to stop.
- w_rdy  in  NWORKERS  worker idle and able to accept start.
- w_done  in  NWORKERS  one-cycle pulse at block completion.
- w_found  in  NWORKERS  qualifies w_done; block contained the key.
- w_key  in  NWORKERS*KEY_W  found key; valid with w_done&w_found.

## Operation
- Internal state: `next_base` (KEY_W+1 bits, so exhaustion is detectable), `busy[NWORKERS]`, `hit`.
- States: IDLE, RUN, ABORT, DONE.
- IDLE: rdy=1. en → clear key_valid/key/busy/hit, next_base=0, go RUN.
- RUN dispatch: at most one dispatch per cycle, to the lowest index i with w_rdy[i] & !busy[i], only while next_base < 2^KEY_W.
  - w_start[i]=1.
  - w_base[i]=next_base[KEY_W−1:0].
  - next_base += 2^BLOCK_LOG.
  - busy[i]=1.
- RUN completion: w_done[i] clears busy[i]. A worker is never re-dispatched in the cycle its w_done is seen.
  - If w_found[i]: latch key=w_key[i], set hit, go ABORT.
  - Simultaneous found from several workers: the lowest index wins.
- RUN exhaustion: next_base = 2^KEY_W, all busy clear, no hit → DONE with key_valid=0.
- ABORT: w_abort=1, no w_start. Stay until all w_rdy=1; then clear busy and go DONE with key_valid=1.
  - w_done/w_found arriving in ABORT or DONE is ignored; the latched key is unchanged.
- DONE: rdy=1, key/key_valid held. en → same as from IDLE (restart at base 0).
- en while rdy=0 is ignored.
- Reset, at any time including mid-run: state IDLE.
  - rdy=1; key_valid=0, key=0.
  - w_start=0, w_base=0, w_abort=0.
  - busy=0, next_base=0.

## Timing
- All outputs registered.
- en sampled at cycle t → first w_start at t+1; rdy low from t+1.
- w_done&w_found at cycle t → key/hit latched and w_abort high at t+1; no w_start at or after t+1.
- Last w_rdy rising at cycle t in ABORT → w_abort low, rdy and key_valid high at t+1.
- Exhaustion: final w_done at t → rdy high at t+1.
- w_start pulses are exactly one cycle wide. w_base[i] updates in the same cycle as w_start[i].
- Block bases are issued in strictly increasing order with no gaps or repeats: 2^(KEY_W−BLOCK_LOG) starts per full run.

## Test plan
Defaults, behavioural worker models with a 5-cycle job latency.

- Reset: assert rst_n=0 mid-run → next cycle rdy=1, key_valid=0, key=0, w_start=0, w_abort=0; after en, the first w_base is 0x000000.
- No hit: en → 16 w_start pulses, bases 0x000000, 0x100000 … 0xF00000 in order, alternating w0/w1; rdy=1 one cycle after the 16th w_done; key_valid=0.
- Hit: model reports found key 0x3ABCDE in block 0x300000 → w_abort next cycle, no further w_start, key=0x3ABCDE, key_valid=1 after both w_rdy=1.
- Simultaneous hits: w0 key 0x000007 and w1 key 0x100005 found in the same cycle → key=0x000007. A later w_done with found from w1 during ABORT leaves key unchanged.
- Protocol: en pulsed during RUN → ignored (base sequence unaltered). en in DONE → key_valid drops next cycle and a new run starts at 0x000000.
- Stalled worker: hold w1 w_rdy=0 throughout → all 16 blocks go to w0 in order; the run completes normally.
